// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: branch counter
// encodings, instruction stride and BTB field-width helpers.
package fetch_pkg;

    // 2-bit saturating branch counter states.
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // Bytes per instruction; the sequential successor of a PC.
    localparam int INSTR_STRIDE = 4;

    // Number of PC bits used to index a BTB with the given depth.
    function automatic int index_width(input int entries);
        return $clog2(entries);
    endfunction

    // PC bits above the index and the byte offset form the tag.
    function automatic int tag_width(input int data_width, input int entries);
        return data_width - $clog2(entries) - 2;
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer of 2-bit saturating counters.
// The lookup port is purely combinational on the stored state; the update
// port writes at the clock edge, so a same-cycle lookup of the entry being
// updated sees the old contents.
module branch_target_buffer
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BTB_ENTRIES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] lookup_pc,
    output logic                  lookup_taken,
    output logic [DATA_WIDTH-1:0] lookup_target,
    input  logic                  upd_valid,
    input  logic [DATA_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [DATA_WIDTH-1:0] upd_target
);

    localparam int IW = index_width(BTB_ENTRIES);
    localparam int TW = tag_width(DATA_WIDTH, BTB_ENTRIES);

    logic [BTB_ENTRIES-1:0] valid_q, valid_d;
    logic [TW-1:0]          tag_q    [BTB_ENTRIES];
    logic [TW-1:0]          tag_d    [BTB_ENTRIES];
    logic [DATA_WIDTH-1:0]  target_q [BTB_ENTRIES];
    logic [DATA_WIDTH-1:0]  target_d [BTB_ENTRIES];
    logic [1:0]             ctr_q    [BTB_ENTRIES];
    logic [1:0]             ctr_d    [BTB_ENTRIES];

    logic [IW-1:0] l_idx, u_idx;
    logic [TW-1:0] l_tag, u_tag;
    logic          l_hit, u_hit;

    // The byte offset within a word never takes part in the lookup.
    logic unused_byte_offset;
    assign unused_byte_offset = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign l_idx = lookup_pc[IW+1:2];
    assign l_tag = lookup_pc[DATA_WIDTH-1:IW+2];
    assign u_idx = upd_pc[IW+1:2];
    assign u_tag = upd_pc[DATA_WIDTH-1:IW+2];

    // Lookup: taken only on a valid tag hit whose counter is in a taken state.
    always_comb begin
        l_hit         = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
        lookup_taken  = l_hit && ctr_q[l_idx][1];
        lookup_target = target_q[l_idx];
    end

    // Update: train the counter on a hit, allocate on a taken miss.
    always_comb begin
        // NOTE: every next-state variable starts from its current value so
        // no path through the branches below leaves it unassigned (no latch).
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        if (upd_valid) begin
            if (u_hit) begin
                if (upd_taken) begin
                    if (ctr_q[u_idx] != CTR_ST) ctr_d[u_idx] = ctr_q[u_idx] + 2'd1;
                    target_d[u_idx] = upd_target;
                end else if (ctr_q[u_idx] != CTR_SNT) begin
                    ctr_d[u_idx] = ctr_q[u_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                valid_d[u_idx]  = 1'b1;
                tag_d[u_idx]    = u_tag;
                target_d[u_idx] = upd_target;
                ctr_d[u_idx]    = CTR_WT;
            end
        end
    end

    // Entry storage; reset clears every entry at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the arrays sit in flops with an async reset because a
            // stale valid bit after reset would produce a bogus prediction;
            // an SRAM macro could not be cleared in a single cycle.
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, BTB-based next-PC prediction and
// EX-stage redirect. Outputs depend only on stored state.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    BTB_ENTRIES = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  EX_update,
    input  logic [DATA_WIDTH-1:0] EX_PC,
    input  logic                  EX_taken,
    input  logic [DATA_WIDTH-1:0] EX_target,
    input  logic                  EX_mispredict,
    input  logic [DATA_WIDTH-1:0] EX_redirect_PC,
    output logic [DATA_WIDTH-1:0] IF_PC,
    output logic                  IF_taken,
    output logic [DATA_WIDTH-1:0] IF_next_PC
);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] btb_target;
    logic                  btb_taken;

    branch_target_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BTB_ENTRIES(BTB_ENTRIES)
    ) u_btb (
        .clk          (clk),
        .rst          (rst),
        .lookup_pc    (pc_q),
        .lookup_taken (btb_taken),
        .lookup_target(btb_target),
        .upd_valid    (EX_update),
        .upd_pc       (EX_PC),
        .upd_taken    (EX_taken),
        .upd_target   (EX_target)
    );

    // Prediction outputs; the increment wraps modulo 2^DATA_WIDTH.
    always_comb begin
        IF_PC      = pc_q;
        IF_taken   = btb_taken;
        IF_next_PC = btb_taken ? btb_target : pc_q + DATA_WIDTH'(INSTR_STRIDE);
    end

    // Next PC: a redirect overrides a stall, otherwise advance when enabled.
    always_comb begin
        pc_d = pc_q;
        if (EX_mispredict) pc_d = EX_redirect_PC;
        else if (en)       pc_d = IF_next_PC;
    end

    // PC register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_q <= RESET_PC;
        else      pc_q <= pc_d;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: expected fetch state is pushed to a
// scoreboard when stimulus is driven and compared one cycle later.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, en, ex_update, ex_taken, ex_mispredict;
    logic [31:0] ex_pc, ex_target, ex_redirect_pc;
    logic [31:0] if_pc, if_next_pc, w_pc, w_next;
    logic        if_taken, w_taken;

    always #5 clk = ~clk;

    fetch_unit #(.DATA_WIDTH(32), .BTB_ENTRIES(8), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst(rst), .en(en), .EX_update(ex_update), .EX_PC(ex_pc),
        .EX_taken(ex_taken), .EX_target(ex_target), .EX_mispredict(ex_mispredict),
        .EX_redirect_PC(ex_redirect_pc), .IF_PC(if_pc), .IF_taken(if_taken),
        .IF_next_PC(if_next_pc)
    );

    fetch_unit #(.DATA_WIDTH(32), .BTB_ENTRIES(8), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .EX_update(ex_update), .EX_PC(ex_pc),
        .EX_taken(ex_taken), .EX_target(ex_target), .EX_mispredict(ex_mispredict),
        .EX_redirect_PC(ex_redirect_pc), .IF_PC(w_pc), .IF_taken(w_taken),
        .IF_next_PC(w_next)
    );

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] next;
    } exp_t;

    typedef struct {
        logic        en, upd;
        logic [31:0] epc;
        logic        tk;
        logic [31:0] tgt;
        logic        mp;
        logic [31:0] rpc;
        exp_t        x;
    } stim_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic drive(input logic e, input logic upd, input logic [31:0] epc,
                         input logic tk, input logic [31:0] tgt,
                         input logic mp, input logic [31:0] rpc);
        en = e; ex_update = upd; ex_pc = epc; ex_taken = tk;
        ex_target = tgt; ex_mispredict = mp; ex_redirect_pc = rpc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic stim_t st(input logic e, input logic upd, input logic [31:0] epc,
                                 input logic tk, input logic [31:0] tgt,
                                 input logic mp, input logic [31:0] rpc,
                                 input logic [31:0] xpc, input logic xtk,
                                 input logic [31:0] xnx);
        stim_t s;
        s.en = e; s.upd = upd; s.epc = epc; s.tk = tk; s.tgt = tgt;
        s.mp = mp; s.rpc = rpc;
        s.x.pc = xpc; s.x.taken = xtk; s.x.next = xnx;
        return s;
    endfunction

    task automatic test_reset();
        stim_t tbl[$];
        exp_t  e;
        rst = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        checks++;
        if (if_pc !== 32'h0 || if_taken !== 1'b0 || if_next_pc !== 32'h4) begin
            failures++;
            $display("FAIL reset_state: got pc=%h taken=%b next=%h, want pc=0 taken=0 next=4",
                     if_pc, if_taken, if_next_pc);
        end
        rst = 1'b1;
        tbl.push_back(st(1, 0, 0, 0, 0, 0, 0, 32'h4, 0, 32'h8));
        tbl.push_back(st(1, 0, 0, 0, 0, 0, 0, 32'h8, 0, 32'hC));
        tbl.push_back(st(1, 0, 0, 0, 0, 0, 0, 32'hC, 0, 32'h10));
        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].upd, tbl[i].epc, tbl[i].tk, tbl[i].tgt, tbl[i].mp, tbl[i].rpc);
            sb.push_back(tbl[i].x);
            tick();
            e = sb.pop_front();
            checks++;
            if (if_pc !== e.pc || if_taken !== e.taken || if_next_pc !== e.next) begin
                failures++;
                $display("FAIL seq_fetch[%0d]: got pc=%h taken=%b next=%h, want pc=%h taken=%b next=%h",
                         i, if_pc, if_taken, if_next_pc, e.pc, e.taken, e.next);
            end
        end
    endtask

    task automatic test_stall_redirect();
        stim_t tbl[$];
        exp_t  e;
        tbl.push_back(st(1, 0, 0, 0, 0, 1, 32'h8,   32'h8,   0, 32'hC));
        tbl.push_back(st(0, 0, 0, 0, 0, 0, 0,       32'h8,   0, 32'hC));
        tbl.push_back(st(0, 0, 0, 0, 0, 0, 0,       32'h8,   0, 32'hC));
        tbl.push_back(st(0, 0, 0, 0, 0, 0, 0,       32'h8,   0, 32'hC));
        tbl.push_back(st(0, 0, 0, 0, 0, 1, 32'h100, 32'h100, 0, 32'h104));
        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].upd, tbl[i].epc, tbl[i].tk, tbl[i].tgt, tbl[i].mp, tbl[i].rpc);
            sb.push_back(tbl[i].x);
            tick();
            e = sb.pop_front();
            checks++;
            if (if_pc !== e.pc || if_taken !== e.taken || if_next_pc !== e.next) begin
                failures++;
                $display("FAIL stall_redirect[%0d]: got pc=%h taken=%b next=%h, want pc=%h taken=%b next=%h",
                         i, if_pc, if_taken, if_next_pc, e.pc, e.taken, e.next);
            end
        end
    endtask

    task automatic test_allocate();
        stim_t tbl[$];
        exp_t  e;
        tbl.push_back(st(1, 1, 32'h10, 1, 32'h40, 1, 32'h40, 32'h40, 0, 32'h44));
        tbl.push_back(st(1, 0, 0,      0, 0,      1, 32'h10, 32'h10, 1, 32'h40));
        tbl.push_back(st(1, 0, 0,      0, 0,      0, 0,      32'h40, 0, 32'h44));
        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].upd, tbl[i].epc, tbl[i].tk, tbl[i].tgt, tbl[i].mp, tbl[i].rpc);
            sb.push_back(tbl[i].x);
            tick();
            e = sb.pop_front();
            checks++;
            if (if_pc !== e.pc || if_taken !== e.taken || if_next_pc !== e.next) begin
                failures++;
                $display("FAIL allocate[%0d]: got pc=%h taken=%b next=%h, want pc=%h taken=%b next=%h",
                         i, if_pc, if_taken, if_next_pc, e.pc, e.taken, e.next);
            end
        end
    endtask

    task automatic test_hysteresis();
        stim_t tbl[$];
        exp_t  e;
        // Park IF_PC on 0x10 (counter WT) and train the entry while stalled.
        tbl.push_back(st(0, 0, 0,      0, 0,      1, 32'h10, 32'h10, 1, 32'h40));
        tbl.push_back(st(0, 1, 32'h10, 0, 0,      0, 0,      32'h10, 0, 32'h14)); // WNT
        tbl.push_back(st(0, 1, 32'h10, 0, 0,      0, 0,      32'h10, 0, 32'h14)); // SNT
        tbl.push_back(st(0, 1, 32'h10, 1, 32'h40, 0, 0,      32'h10, 0, 32'h14)); // WNT
        tbl.push_back(st(0, 1, 32'h10, 1, 32'h40, 0, 0,      32'h10, 1, 32'h40)); // WT
        tbl.push_back(st(0, 1, 32'h10, 1, 32'h48, 0, 0,      32'h10, 1, 32'h48)); // ST, new target
        tbl.push_back(st(0, 1, 32'h10, 0, 32'h99, 0, 0,      32'h10, 1, 32'h48)); // WT, target kept
        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].upd, tbl[i].epc, tbl[i].tk, tbl[i].tgt, tbl[i].mp, tbl[i].rpc);
            sb.push_back(tbl[i].x);
            tick();
            e = sb.pop_front();
            checks++;
            if (if_pc !== e.pc || if_taken !== e.taken || if_next_pc !== e.next) begin
                failures++;
                $display("FAIL hysteresis[%0d]: got pc=%h taken=%b next=%h, want pc=%h taken=%b next=%h",
                         i, if_pc, if_taken, if_next_pc, e.pc, e.taken, e.next);
            end
        end
    endtask

    task automatic test_alias();
        stim_t tbl[$];
        exp_t  e;
        tbl.push_back(st(0, 0, 0,      0, 0,      1, 32'h30, 32'h30, 0, 32'h34));
        tbl.push_back(st(0, 1, 32'h30, 0, 32'h77, 0, 0,      32'h30, 0, 32'h34)); // miss NT: no alloc
        tbl.push_back(st(0, 0, 0,      0, 0,      1, 32'h10, 32'h10, 1, 32'h48));
        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].upd, tbl[i].epc, tbl[i].tk, tbl[i].tgt, tbl[i].mp, tbl[i].rpc);
            sb.push_back(tbl[i].x);
            tick();
            e = sb.pop_front();
            checks++;
            if (if_pc !== e.pc || if_taken !== e.taken || if_next_pc !== e.next) begin
                failures++;
                $display("FAIL alias[%0d]: got pc=%h taken=%b next=%h, want pc=%h taken=%b next=%h",
                         i, if_pc, if_taken, if_next_pc, e.pc, e.taken, e.next);
            end
        end
    endtask

    task automatic test_collision();
        exp_t e;
        // IF_PC=0x10 with counter WT; update the same entry not-taken.
        drive(0, 1, 32'h10, 0, 0, 0, 0);
        sb.push_back(exp_t'{32'h10, 1'b0, 32'h14});
        #1;
        checks++;
        if (if_taken !== 1'b1 || if_next_pc !== 32'h48) begin
            failures++;
            $display("FAIL collision_old: got taken=%b next=%h, want taken=1 next=00000048",
                     if_taken, if_next_pc);
        end
        tick();
        e = sb.pop_front();
        checks++;
        if (if_pc !== e.pc || if_taken !== e.taken || if_next_pc !== e.next) begin
            failures++;
            $display("FAIL collision_new: got pc=%h taken=%b next=%h, want pc=%h taken=%b next=%h",
                     if_pc, if_taken, if_next_pc, e.pc, e.taken, e.next);
        end
    endtask

    task automatic test_wrap_reset();
        exp_t e;
        // Update and redirect in flight when reset hits mid-cycle.
        drive(1, 1, 32'h10, 1, 32'h80, 1, 32'h200);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (if_pc !== 32'h0 || if_taken !== 1'b0 || if_next_pc !== 32'h4) begin
            failures++;
            $display("FAIL async_reset: got pc=%h taken=%b next=%h, want pc=0 taken=0 next=4",
                     if_pc, if_taken, if_next_pc);
        end
        checks++;
        if (w_pc !== 32'hFFFF_FFFC || w_taken !== 1'b0 || w_next !== 32'h0) begin
            failures++;
            $display("FAIL wrap_reset: got pc=%h taken=%b next=%h, want pc=fffffffc taken=0 next=0",
                     w_pc, w_taken, w_next);
        end
        tick();
        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);
        sb.push_back(exp_t'{32'h4, 1'b0, 32'h8});
        tick();
        e = sb.pop_front();
        checks++;
        if (if_pc !== e.pc || if_taken !== e.taken || if_next_pc !== e.next) begin
            failures++;
            $display("FAIL post_reset: got pc=%h taken=%b next=%h, want pc=%h taken=%b next=%h",
                     if_pc, if_taken, if_next_pc, e.pc, e.taken, e.next);
        end
        checks++;
        if (w_pc !== 32'h0 || w_next !== 32'h4) begin
            failures++;
            $display("FAIL wrap_pc: got pc=%h next=%h, want pc=0 next=4", w_pc, w_next);
        end
        // BTB was cleared and the in-flight allocate discarded.
        drive(0, 0, 0, 0, 0, 1, 32'h10);
        sb.push_back(exp_t'{32'h10, 1'b0, 32'h14});
        tick();
        e = sb.pop_front();
        checks++;
        if (if_pc !== e.pc || if_taken !== e.taken || if_next_pc !== e.next) begin
            failures++;
            $display("FAIL btb_cleared: got pc=%h taken=%b next=%h, want pc=%h taken=%b next=%h",
                     if_pc, if_taken, if_next_pc, e.pc, e.taken, e.next);
        end
    endtask

    initial begin
        test_reset();
        test_stall_redirect();
        test_allocate();
        test_hysteresis();
        test_alias();
        test_collision();
        test_wrap_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
